// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader and the processor it feeds.
// Holds the default memory geometry and the loader state encoding.
package imem_boot_loader_pkg;

  localparam int DEF_IM_DEPTH = 256;
  localparam int DEF_ADDR_W   = 16;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CSUM_HI,
    CSUM_LO,
    DONE,
    ERROR
  } load_state_e;

  // The states in which the loader is consuming bytes from the stream.
  function automatic logic is_rx_state(input load_state_e s);
    return (s == LEN_HI)  || (s == LEN_LO)  ||
           (s == DATA_HI) || (s == DATA_LO) ||
           (s == CSUM_HI) || (s == CSUM_LO);
  endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Pairs big-endian bytes into 16-bit words and keeps the running 16-bit sum of data words.
// The held high byte is shared by the length, data and checksum fields.
module loader_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        hi_load,
  input  logic        word_load,
  input  logic [7:0]  byte_in,
  output logic [15:0] word,
  output logic [15:0] csum
);

  logic [7:0] hi_q;

  // The word is formed while the low byte is still on the bus, so the
  // consumer can act on it in the same cycle as the low-byte handshake.
  assign word = {hi_q, byte_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      csum <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge
      // values, so register order in the block does not matter.
      if (hi_load) hi_q <= byte_in;
      if (clear)          csum <= '0;
      else if (word_load) csum <= csum + word;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a length-prefixed, checksummed byte stream and writes it into instruction memory,
// holding the processor in reset until a load completes cleanly.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int IM_DEPTH = DEF_IM_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wdata,
  output logic              cpu_reset,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [15:0] MAX_WORDS = 16'(IM_DEPTH);

  load_state_e state_q, state_d;
  logic [15:0] len_q, word_cnt_q;
  logic [15:0] pk_word, pk_csum;
  logic        xfer, start_ok, hi_load, word_load, len_load;

  assign rx_ready  = is_rx_state(state_q);
  assign load_busy = rx_ready;
  assign load_done = (state_q == DONE);
  assign load_err  = (state_q == ERROR);
  assign xfer      = rx_valid && rx_ready;

  loader_word_packer u_packer (
    .clk       (clk),
    .rst       (reset),
    .clear     (start_ok),
    .hi_load   (hi_load),
    .word_load (word_load),
    .byte_in   (rx_data),
    .word      (pk_word),
    .csum      (pk_csum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    start_ok  = 1'b0;
    hi_load   = 1'b0;
    word_load = 1'b0;
    len_load  = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = LEN_HI;
        end
      end
      LEN_HI, DATA_HI, CSUM_HI: begin
        if (xfer) begin
          hi_load = 1'b1;
          state_d = (state_q == LEN_HI)  ? LEN_LO :
                    (state_q == DATA_HI) ? DATA_LO : CSUM_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_load = 1'b1;
          if (pk_word == 16'd0)           state_d = CSUM_HI;
          else if (pk_word > MAX_WORDS)   state_d = ERROR;
          else                            state_d = DATA_HI;
        end
      end
      DATA_LO: begin
        if (xfer) begin
          word_load = 1'b1;
          state_d   = (word_cnt_q + 16'd1 == len_q) ? CSUM_HI : DATA_HI;
        end
      end
      CSUM_LO: begin
        if (xfer) state_d = (pk_word == pk_csum) ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write port is registered: the word lands one cycle after its low byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q      <= '0;
      word_cnt_q <= '0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_reset  <= 1'b1;
    end else begin
      im_we <= word_load;
      if (start_ok) begin
        len_q      <= '0;
        word_cnt_q <= '0;
        cpu_reset  <= 1'b1;
      end
      if (len_load) len_q <= pk_word;
      if (word_load) begin
        im_addr    <= ADDR_W'(word_cnt_q);
        im_wdata   <= pk_word;
        word_cnt_q <= word_cnt_q + 16'd1;
      end
      if (state_d == DONE && state_q != DONE) cpu_reset <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: stream-level reference model, per-cycle
// write/invariant monitor, directed loads plus randomized streams and stalls.
module tb_imem_boot_loader;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, im_we, cpu_reset, load_busy, load_done, load_err;
  logic [15:0] im_addr, im_wdata;

  always #5 clk = ~clk;

  imem_boot_loader #(.IM_DEPTH(DEPTH), .ADDR_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .cpu_reset (cpu_reset),
    .load_busy (load_busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          pcyc     = 0;
  wr_t         exp_q[$];
  logic [31:0] wr_log[$];
  logic [7:0]  stream[$];

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle monitor: writes must appear exactly when the model scheduled them.
  always @(negedge clk) begin
    if (!reset) begin
      check("ready_eq_busy", rx_ready, load_busy);
      check("cpu_reset_eq_not_done", cpu_reset, !load_done);
      if (exp_q.size() > 0 && exp_q[0].due < pcyc) begin
        check("write_cycle", pcyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].due == pcyc) begin
        check("im_we", im_we, 1'b1);
        check("im_addr", im_addr, exp_q[0].addr);
        check("im_wdata", im_wdata, exp_q[0].data);
        void'(exp_q.pop_front());
      end else if (im_we) begin
        check("spurious_we", im_we, 1'b0);
      end
      if (im_we) wr_log.push_back({im_addr, im_wdata});
    end
  end

  function automatic int stream_len();
    return (stream.size() >= 2) ? int'({stream[0], stream[1]}) : 0;
  endfunction

  // mode 0: full rate, 1: valid toggles every cycle, 2: random valid.
  task automatic send_bytes(input int mode, input int start_at);
    int n;
    n = stream_len();
    for (int i = 0; i < stream.size(); i++) begin
      int waited = 0;
      int dcyc   = 0;
      bit hs     = 1'b0;
      while (!hs && waited < 200) begin
        @(negedge clk);
        rx_data  = stream[i];
        rx_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ~rx_valid : 1'($urandom_range(1, 0));
        start    = (i == start_at && waited == 0);
        hs       = rx_valid && rx_ready;
        dcyc     = pcyc;
        @(posedge clk);
        waited++;
      end
      if (!hs) begin
        check("byte_accepted", i, stream.size());
        break;
      end
      if (n <= DEPTH && i >= 3 && (i % 2) == 1 && i <= 2 * n + 1)
        exp_q.push_back('{dcyc + 1, 16'((i - 3) / 2), {stream[i-1], stream[i]}});
    end
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", load_busy, 1'b1);
    check("cpu_reset_after_start", cpu_reset, 1'b1);
    check("done_cleared", load_done, 1'b0);
    check("err_cleared", load_err, 1'b0);
  endtask

  // Full load plus end-of-load checks against the stream-level model.
  task automatic run_load(input int mode, input int start_at);
    int          n;
    bit          ok;
    logic [15:0] sum;
    n   = stream_len();
    sum = '0;
    if (n > DEPTH) ok = 1'b0;
    else begin
      for (int j = 0; j < n; j++) sum += {stream[2+2*j], stream[3+2*j]};
      ok = (sum == {stream[2*n+2], stream[2*n+3]});
    end
    wr_log.delete();
    do_start();
    send_bytes(mode, start_at);
    repeat (3) @(negedge clk);
    check("load_done", load_done, ok);
    check("load_err", load_err, !ok);
    check("cpu_reset_end", cpu_reset, !ok);
    check("rx_ready_end", rx_ready, 1'b0);
    check("pending_writes", exp_q.size(), 0);
    check("write_count", wr_log.size(), (n <= DEPTH) ? n : 0);
  endtask

  task automatic set_t1(input logic [7:0] csum_lo);
    stream = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBE, csum_lo};
  endtask

  task automatic pin_t1_writes(input string tag);
    check({tag, "_nwr"}, wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      check({tag, "_wr0"}, wr_log[0], 32'h0000_1234);
      check({tag, "_wr1"}, wr_log[1], 32'h0001_ABCD);
      check({tag, "_wr2"}, wr_log[2], 32'h0002_0001);
    end
  endtask

  task automatic set_random(input int n, input bit corrupt);
    logic [15:0] w, sum;
    sum    = '0;
    stream = '{8'(n >> 8), 8'(n)};
    for (int j = 0; j < n; j++) begin
      w = 16'($urandom);
      sum += w;
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
    end
    if (corrupt) sum ^= 16'(1 << $urandom_range(15, 0));
    stream.push_back(sum[15:8]);
    stream.push_back(sum[7:0]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    #1;
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_im_we", im_we, 1'b0);
    check("rst_busy", load_busy, 1'b0);
    check("rst_done", load_done, 1'b0);
    check("rst_err", load_err, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // T1 nominal
    set_t1(8'h02);
    run_load(0, -1);
    pin_t1_writes("t1");
    check("t1_done", load_done, 1'b1);

    // T2 checksum mismatch
    set_t1(8'h03);
    run_load(0, -1);
    check("t2_err", load_err, 1'b1);
    check("t2_cpu_reset", cpu_reset, 1'b1);

    // T3 oversize count; further bytes are never accepted
    stream = '{8'h01, 8'h01};
    run_load(0, -1);
    check("t3_err", load_err, 1'b1);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_no_ready", rx_ready, 1'b0);
    end
    rx_valid = 1'b0;

    // T4 zero length
    stream = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_load(0, -1);
    check("t4_done", load_done, 1'b1);

    // T5 toggled valid with a start pulse mid-load
    set_t1(8'h02);
    run_load(1, 4);
    pin_t1_writes("t5");

    // Randomized streams with random stalls
    for (int r = 0; r < 12; r++) begin
      set_random($urandom_range(6, 0), ($urandom_range(3, 0) == 0));
      run_load(2, $urandom_range(9, 2));
    end

    // Boundary: exactly IM_DEPTH words accepted
    set_random(DEPTH, 1'b0);
    run_load(0, -1);
    check("depth_done", load_done, 1'b1);

    // T6 async reset after the second word is written
    set_t1(8'h02);
    stream = stream[0:5];
    wr_log.delete();
    do_start();
    send_bytes(0, -1);
    for (int k = 0; k < 10 && wr_log.size() < 2; k++) @(negedge clk);
    check("t6_two_writes", wr_log.size(), 2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_cpu_reset", cpu_reset, 1'b1);
    check("t6_rx_ready", rx_ready, 1'b0);
    check("t6_busy", load_busy, 1'b0);
    check("t6_im_we", im_we, 1'b0);
    check("t6_done", load_done, 1'b0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    set_t1(8'h02);
    run_load(0, -1);
    pin_t1_writes("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
